// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the fetch stage and the controller.
//  fetch_state_t : fetch FSM encoding
//  NOP_INSTR     : canonical RV32 NOP (addi x0, x0, 0) shown in IF/ID when empty
//  OPC_*         : base opcode field values used by decode/control
package pipe_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned OPCODE_W  = 7;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b010_0011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b011_0011;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b011_0111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b110_0111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b110_1111;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b111_0011;

    // Opcode field of a 32-bit instruction word.
    function automatic logic [OPCODE_W-1:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_W-1:0];
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_fetch_if.sv
// pipe_fetch_if: instruction-memory request/response bus.
//  imem_req_o    : fetch request strobe (one cycle per request)
//  imem_addr_o   : word-aligned fetch address
//  imem_rvalid_i : response valid, one or more cycles after the request
//  imem_rdata_i  : fetched instruction word
// master = fetch stage, slave = instruction memory.
interface pipe_fetch_if #(
    parameter int unsigned X_LEN = 32
);
    logic             imem_req_o;
    logic [X_LEN-1:0] imem_addr_o;
    logic             imem_rvalid_i;
    logic [X_LEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface : pipe_fetch_if

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: one-entry data+valid holding register.
//  clk_i, rst_i : clock, asynchronous active-high reset
//  i_load       : capture i_data and mark the entry full
//  i_clear      : empty the entry (wins over i_load)
//  i_data       : word to capture
//  o_valid      : entry is full
//  o_data       : held word
module pipe_skid_buf #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Entry register; clear takes priority so a redirect always flushes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : pipe_skid_buf

// File: rtl/pipe_fetch.sv
// pipe_fetch: instruction fetch stage with integrated IF/ID register.
//  clk_i, rst_i   : clock, asynchronous active-high reset
//  imem           : instruction-memory bus (master side), single outstanding request
//  redirect_i     : taken branch/jump from EX; redirect_pc_i is the target
//  stall_i        : decode cannot accept, IF/ID holds
//  valid_o        : IF/ID holds a live instruction
//  instr_o, pc_o  : IF/ID instruction (NOP when empty) and its PC
//  rs1/rs2/rd_addr_o : register index fields of instr_o
module pipe_fetch
    import pipe_pkg::*;
#(
    parameter int unsigned      X_LEN    = 32,
    parameter logic [X_LEN-1:0] RESET_PC = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipe_fetch_if.master         imem,
    input  logic                 redirect_i,
    input  logic [X_LEN-1:0]     redirect_pc_i,
    input  logic                 stall_i,
    output logic                 valid_o,
    output logic [X_LEN-1:0]     instr_o,
    output logic [X_LEN-1:0]     pc_o,
    output logic [REG_IDX_W-1:0] rs1_addr_o,
    output logic [REG_IDX_W-1:0] rs2_addr_o,
    output logic [REG_IDX_W-1:0] rd_addr_o
);

    localparam logic [X_LEN-1:0] PC_STEP    = X_LEN'(4);
    localparam logic [X_LEN-1:0] ALIGN_MASK = ~X_LEN'(3);
    localparam logic [X_LEN-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;
    localparam logic [X_LEN-1:0] NOP_WORD   = X_LEN'(NOP_INSTR);

    fetch_state_t     r_state;
    logic [X_LEN-1:0] r_pc;
    logic             r_drop;
    logic             r_valid;
    logic [X_LEN-1:0] r_instr;
    logic [X_LEN-1:0] r_pc_out;
    logic             r_imem_req;
    logic [X_LEN-1:0] r_imem_addr;

    fetch_state_t     w_state_nxt;
    logic [X_LEN-1:0] w_pc_nxt;
    logic             w_drop_nxt;
    logic             w_valid_nxt;
    logic [X_LEN-1:0] w_instr_nxt;
    logic [X_LEN-1:0] w_pc_out_nxt;
    logic             w_load;
    logic [X_LEN-1:0] w_load_data;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic             w_skid_valid;
    logic [X_LEN-1:0] w_skid_data;
    logic             w_ifid_free;
    logic [X_LEN-1:0] w_pc_inc;
    logic [X_LEN-1:0] w_redir_pc;

    assign w_ifid_free = !r_valid || !stall_i;
    assign w_pc_inc    = r_pc + PC_STEP;   // wraps modulo 2^X_LEN
    assign w_redir_pc  = redirect_pc_i & ALIGN_MASK;

    // Holds a returned word while IF/ID is stalled.
    pipe_skid_buf #(
        .W (X_LEN)
    ) u_skid (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (imem.imem_rdata_i),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // Next-state, PC, drop flag and IF/ID update.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_drop_nxt   = r_drop;
        w_load       = 1'b0;
        w_load_data  = imem.imem_rdata_i;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_valid_nxt  = r_valid;
        w_instr_nxt  = r_instr;
        w_pc_out_nxt = r_pc_out;

        unique case (r_state)
            S_RESET: w_state_nxt = S_REQ;
            S_REQ:   w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem.imem_rvalid_i) begin
                    if (r_drop) begin
                        // Response to a fetch made before a redirect.
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else if (w_ifid_free) begin
                        w_load      = 1'b1;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_skid_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i && w_skid_valid) begin
                    w_load       = 1'b1;
                    w_load_data  = w_skid_data;
                    w_pc_nxt     = w_pc_inc;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = S_REQ;
                end
            end
            default: w_state_nxt = S_RESET;
        endcase

        // Redirect overrides stall and response handling.
        if (redirect_i) begin
            w_pc_nxt     = w_redir_pc;
            w_load       = 1'b0;
            w_skid_load  = 1'b0;
            w_skid_clear = 1'b1;
            unique case (r_state)
                S_WAIT: begin
                    if (imem.imem_rvalid_i) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = S_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_REQ: begin
                    // The request for the old PC is already on the bus.
                    w_drop_nxt  = 1'b1;
                    w_state_nxt = S_WAIT;
                end
                default: begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                end
            endcase
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_WORD;
        end else if (w_load) begin
            w_valid_nxt  = 1'b1;
            w_instr_nxt  = w_load_data;
            w_pc_out_nxt = r_pc;
        end else if (!stall_i) begin
            // Bubble: decode consumed IF/ID and nothing new arrived.
            w_valid_nxt = 1'b0;
            w_instr_nxt = NOP_WORD;
        end
    end

    // State, PC and IF/ID registers; the request strobe is registered from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_RESET;
            r_pc        <= RESET_PC_A;
            r_drop      <= 1'b0;
            r_valid     <= 1'b0;
            r_instr     <= NOP_WORD;
            r_pc_out    <= '0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC_A;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop      <= w_drop_nxt;
            r_valid     <= w_valid_nxt;
            r_instr     <= w_instr_nxt;
            r_pc_out    <= w_pc_out_nxt;
            r_imem_req  <= (w_state_nxt == S_REQ);
            r_imem_addr <= w_pc_nxt;
        end
    end

    assign imem.imem_req_o  = r_imem_req;
    assign imem.imem_addr_o = r_imem_addr;

    assign valid_o    = r_valid;
    assign instr_o    = r_instr;
    assign pc_o       = r_pc_out;
    assign rs1_addr_o = r_instr[19:15];
    assign rs2_addr_o = r_instr[24:20];
    assign rd_addr_o  = r_instr[11:7];

endmodule : pipe_fetch
